// File: rtl/axi_wrr_arbit_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package axi_wrr_arbit_pkg;

   localparam int unsigned ARB_WIDTH_DEF = 8;
   localparam int unsigned WEIGHT_W_DEF  = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/axi_wrr_arbit_if.sv
// Request/grant bundle between requester queues (master) and the arbiter (slave).
interface axi_wrr_arbit_if
   import axi_wrr_arbit_pkg::*;
#(
   parameter int unsigned ARB_WIDTH = ARB_WIDTH_DEF,
   parameter int unsigned WEIGHT_W  = WEIGHT_W_DEF
);
   localparam int unsigned IDX_W = $clog2(ARB_WIDTH);

   logic [ARB_WIDTH-1:0]          req_i;
   logic [ARB_WIDTH-1:0]          last_i;
   logic [ARB_WIDTH*WEIGHT_W-1:0] weight_i;
   logic                          gnt_ready_i;
   logic                          gnt_valid_o;
   logic [IDX_W-1:0]              gnt_idx_o;
   logic [ARB_WIDTH-1:0]          gnt_onehot_o;
   logic                          busy_o;

   modport master (
      output req_i, last_i, weight_i, gnt_ready_i,
      input  gnt_valid_o, gnt_idx_o, gnt_onehot_o, busy_o
   );

   modport slave (
      input  req_i, last_i, weight_i, gnt_ready_i,
      output gnt_valid_o, gnt_idx_o, gnt_onehot_o, busy_o
   );

endinterface

// File: rtl/axi_wrr_arbit_rr_pick.sv
// Combinational rotating-priority pick: first set request at or above ptr_i, wrapping to 0.
module axi_wrr_arbit_rr_pick
   import axi_wrr_arbit_pkg::*;
#(
   parameter int unsigned ARB_WIDTH = ARB_WIDTH_DEF,
   parameter int unsigned IDX_W     = $clog2(ARB_WIDTH)
) (
   input  logic [ARB_WIDTH-1:0] req_i,
   input  logic [IDX_W-1:0]     ptr_i,
   output logic                 valid_o,
   output logic [ARB_WIDTH-1:0] onehot_o,
   output logic [IDX_W-1:0]     idx_o
);

   logic [2*ARB_WIDTH-1:0] w_dbl;
   logic [ARB_WIDTH-1:0]   w_rot;
   int unsigned            w_ofs;
   int unsigned            w_pos;

   // Bit k of w_rot is requester (ptr_i + k) mod ARB_WIDTH.
   assign w_dbl   = {req_i, req_i} >> ptr_i;
   assign w_rot   = w_dbl[ARB_WIDTH-1:0];
   assign valid_o = |req_i;

   always_comb begin
      w_ofs = 0;
      for (int k = ARB_WIDTH - 1; k >= 0; k--) begin
         if (w_rot[k]) w_ofs = k;
      end
      w_pos    = (32'(ptr_i) + w_ofs) % ARB_WIDTH;
      onehot_o = valid_o ? (ARB_WIDTH'(1) << w_pos) : '0;
      idx_o    = IDX_W'(onehot_to_idx(32'(onehot_o)));
   end

endmodule

// File: rtl/axi_wrr_arbit.sv
// Weighted round-robin burst arbiter: locks a requester for up to weight bursts per turn,
// with registered grant outputs and a valid/ready beat handshake toward the channel mux.
module axi_wrr_arbit
   import axi_wrr_arbit_pkg::*;
#(
   parameter int unsigned ARB_WIDTH = ARB_WIDTH_DEF,
   parameter int unsigned WEIGHT_W  = WEIGHT_W_DEF
) (
   input logic            clk,
   input logic            rst,
   axi_wrr_arbit_if.slave arb
);

   localparam int unsigned IDX_W = $clog2(ARB_WIDTH);

   arb_state_e           r_state;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     r_gnt_idx;
   logic [ARB_WIDTH-1:0] r_gnt_onehot;
   logic                 r_busy;
   logic [WEIGHT_W-1:0]  r_credit;
   logic                 r_gap_chk;

   logic                 w_pick_valid;
   logic [ARB_WIDTH-1:0] w_pick_onehot;
   logic [IDX_W-1:0]     w_pick_idx;
   logic [WEIGHT_W-1:0]  w_pick_weight;
   logic [IDX_W-1:0]     w_ptr_next;
   logic                 w_valid;
   logic                 w_burst_end;
   logic                 w_gap;

   axi_wrr_arbit_rr_pick #(
      .ARB_WIDTH (ARB_WIDTH),
      .IDX_W     (IDX_W)
   ) u_pick (
      .req_i    (arb.req_i),
      .ptr_i    (r_ptr),
      .valid_o  (w_pick_valid),
      .onehot_o (w_pick_onehot),
      .idx_o    (w_pick_idx)
   );

   assign w_pick_weight = arb.weight_i[w_pick_idx*WEIGHT_W +: WEIGHT_W];
   assign w_ptr_next    = (r_gnt_idx == IDX_W'(ARB_WIDTH - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
   assign w_valid       = r_busy & arb.req_i[r_gnt_idx];
   assign w_burst_end   = w_valid & arb.gnt_ready_i & arb.last_i[r_gnt_idx];
   // Owner went quiet right after finishing a burst: it forfeits the rest of its turn.
   assign w_gap         = r_gap_chk & ~arb.req_i[r_gnt_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ARB_IDLE;
         r_ptr        <= '0;
         r_gnt_idx    <= '0;
         r_gnt_onehot <= '0;
         r_busy       <= 1'b0;
         r_credit     <= '0;
         r_gap_chk    <= 1'b0;
      end else begin
         unique case (r_state)
            ARB_IDLE: begin
               if (w_pick_valid) begin
                  r_state      <= ARB_LOCK;
                  r_gnt_idx    <= w_pick_idx;
                  r_gnt_onehot <= w_pick_onehot;
                  r_busy       <= 1'b1;
                  r_credit     <= (w_pick_weight == '0) ? WEIGHT_W'(1) : w_pick_weight;
                  r_gap_chk    <= 1'b0;
               end
            end
            ARB_LOCK: begin
               r_gap_chk <= 1'b0;
               if (w_gap || (w_burst_end && r_credit <= WEIGHT_W'(1))) begin
                  r_state      <= ARB_IDLE;
                  r_busy       <= 1'b0;
                  r_gnt_onehot <= '0;
                  r_ptr        <= w_ptr_next;
               end else if (w_burst_end) begin
                  r_credit  <= r_credit - WEIGHT_W'(1);
                  r_gap_chk <= 1'b1;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   assign arb.gnt_valid_o  = w_valid;
   assign arb.gnt_idx_o    = r_gnt_idx;
   assign arb.gnt_onehot_o = r_gnt_onehot;
   assign arb.busy_o       = r_busy;

endmodule
